// File: rtl/rom_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arbiter_if
//  Description : Bundle of the requester handshakes (F and D) and the ROM
//                port of the two-requester ROM arbiter.
//                slave  - arbiter side
//                master - requesters + ROM side
//  Ports       : f_req_i/f_addr_i/f_grant_o/f_valid_o/f_data_o   fetch unit
//                d_req_i/d_addr_i/d_grant_o/d_valid_o/d_data_o   data reader
//                rom_addr_o/rom_value_i                          program ROM
//  Revision    : 1.0 - initial release
// ============================================================================
interface rom_arbiter_if #(
    parameter int WORD_SIZE = 20,
    parameter int ADDR_SIZE = 16
);
    logic                 f_req_i;
    logic [ADDR_SIZE-1:0] f_addr_i;
    logic                 f_grant_o;
    logic                 f_valid_o;
    logic [WORD_SIZE-1:0] f_data_o;

    logic                 d_req_i;
    logic [ADDR_SIZE-1:0] d_addr_i;
    logic                 d_grant_o;
    logic                 d_valid_o;
    logic [WORD_SIZE-1:0] d_data_o;

    logic [ADDR_SIZE-1:0] rom_addr_o;
    logic [WORD_SIZE-1:0] rom_value_i;

    modport slave (
        input  f_req_i, f_addr_i, d_req_i, d_addr_i, rom_value_i,
        output f_grant_o, f_valid_o, f_data_o,
        output d_grant_o, d_valid_o, d_data_o,
        output rom_addr_o
    );

    modport master (
        output f_req_i, f_addr_i, d_req_i, d_addr_i, rom_value_i,
        input  f_grant_o, f_valid_o, f_data_o,
        input  d_grant_o, d_valid_o, d_data_o,
        input  rom_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arbiter
//  Description : Shares one single-port, one-cycle-latency program ROM
//                between the fetch unit (F) and the data-table reader (D).
//                At most one grant per cycle; round-robin on ties, or F
//                always wins when FETCH_PRIORITY != 0. The returned word is
//                steered to the requester granted in the previous cycle.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous, active-high reset
//                bus    - rom_arbiter_if.slave (requester handshakes + ROM)
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
    parameter int WORD_SIZE      = 20,
    parameter int ADDR_SIZE      = 16,
    parameter int FETCH_PRIORITY = 0
) (
    input  wire logic     clk,
    input  wire logic     reset,
    rom_arbiter_if.slave  bus
);

    // Requester identifiers, used both for the last-grant pointer and for
    // the response tag.
    localparam logic [0:0] REQ_F = 1'b0;
    localparam logic [0:0] REQ_D = 1'b1;

    logic [0:0]           last_q,      last_d;
    logic [ADDR_SIZE-1:0] addr_hold_q, addr_hold_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [0:0]           rsp_tag_q,   rsp_tag_d;
    logic [WORD_SIZE-1:0] f_data_q,    f_data_d;
    logic [WORD_SIZE-1:0] d_data_q,    d_data_d;

    logic                 tie_to_f;
    logic                 f_win;
    logic                 d_win;
    logic                 any_grant;
    logic [ADDR_SIZE-1:0] rom_addr;
    logic                 f_valid;
    logic                 d_valid;

    // Who wins when both request in the same cycle.
    generate
        if (FETCH_PRIORITY != 0) begin : g_fixed_prio
            assign tie_to_f = 1'b1;
        end else begin : g_round_robin
            assign tie_to_f = (last_q == REQ_D);
        end
    endgenerate

    // F wins whenever it is alone or wins the tie; D takes whatever is left,
    // which makes the two grants mutually exclusive by construction.
    assign f_win     = bus.f_req_i & (~bus.d_req_i | tie_to_f);
    assign d_win     = bus.d_req_i & ~f_win;
    assign any_grant = f_win | d_win;

    // Idle cycles replay the last granted address so the ROM input is quiet.
    always_comb begin
        rom_addr = addr_hold_q;
        if (f_win) begin
            rom_addr = bus.f_addr_i;
        end else if (d_win) begin
            rom_addr = bus.d_addr_i;
        end
    end

    // Response side: the word on rom_value_i belongs to last cycle's grant.
    assign f_valid = rsp_valid_q & (rsp_tag_q == REQ_F);
    assign d_valid = rsp_valid_q & (rsp_tag_q == REQ_D);

    always_comb begin
        last_d      = last_q;
        addr_hold_d = addr_hold_q;
        rsp_valid_d = any_grant;
        rsp_tag_d   = d_win ? REQ_D : REQ_F;
        f_data_d    = f_data_q;
        d_data_d    = d_data_q;

        if (any_grant) begin
            last_d      = d_win ? REQ_D : REQ_F;
            addr_hold_d = rom_addr;
        end
        if (f_valid) begin
            f_data_d = bus.rom_value_i;
        end
        if (d_valid) begin
            d_data_d = bus.rom_value_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= REQ_D;           // F wins the first tie
            addr_hold_q <= '0;
            rsp_valid_q <= 1'b0;            // drops any in-flight read
            rsp_tag_q   <= REQ_F;
            f_data_q    <= '0;
            d_data_q    <= '0;
        end else begin
            last_q      <= last_d;
            addr_hold_q <= addr_hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            f_data_q    <= f_data_d;
            d_data_q    <= d_data_d;
        end
    end

    assign bus.f_grant_o  = f_win;
    assign bus.d_grant_o  = d_win;
    assign bus.rom_addr_o = rom_addr;
    assign bus.f_valid_o  = f_valid;
    assign bus.d_valid_o  = d_valid;
    // Same-cycle passthrough while valid, otherwise the held word.
    assign bus.f_data_o   = f_valid ? bus.rom_value_i : f_data_q;
    assign bus.d_data_o   = d_valid ? bus.rom_value_i : d_data_q;

endmodule
`default_nettype wire
